// File: rtl/matrix_pkg.sv
// Shared types and width helpers for the matrix multiply-accumulate stage.
package matrix_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } mac_state_t;

  // Accumulator width that can hold depth full-scale products without wrapping.
  function automatic int acc_width(input int w, input int depth);
    return 2 * w + $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/matrix_mac_accumulator_if.sv
// Operand stream in, result stream and result array out, plus FSM debug taps.
interface matrix_mac_accumulator_if #(
  parameter int AROWS     = 2,
  parameter int ACOLUMNS  = 2,
  parameter int BCOLUMNS  = 2,
  parameter int WIDTH_BIT = 8
);
  import matrix_pkg::*;

  localparam int ACC_WIDTH = acc_width(WIDTH_BIT, ACOLUMNS);
  localparam int ROW_W     = $clog2(AROWS) + 1;
  localparam int COL_W     = $clog2(BCOLUMNS) + 1;

  // Handshake: a beat transfers on a rising edge where in_valid=1 while busy in RUN.
  // There is no ready; the stage accepts every valid beat in RUN, ignores it elsewhere.
  logic                   start;
  logic                   in_valid;
  logic [WIDTH_BIT-1:0]   Aik;
  logic [WIDTH_BIT-1:0]   Bkj;
  logic                   busy;
  logic                   c_valid;
  logic [ROW_W-1:0]       c_row;
  logic [COL_W-1:0]       c_col;
  logic [ACC_WIDTH-1:0]   c_value;
  logic                   done;
  logic [AROWS-1:0][BCOLUMNS-1:0][ACC_WIDTH-1:0] MatrixC;
  mac_state_t             state;
  logic [ACC_WIDTH-1:0]   acc_dbg;

  modport master (
    output start, in_valid, Aik, Bkj,
    input  busy, c_valid, c_row, c_col, c_value, done, MatrixC, state, acc_dbg
  );

  modport slave (
    input  start, in_valid, Aik, Bkj,
    output busy, c_valid, c_row, c_col, c_value, done, MatrixC, state, acc_dbg
  );

endinterface

// File: rtl/matrix_mac_cell.sv
// Multiplier, adder and partial-sum register for one dot product.
module matrix_mac_cell #(
  parameter int WIDTH_BIT = 8,
  parameter int ACC_WIDTH = 18
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 clear,
  input  logic                 en,
  input  logic                 first,
  input  logic [WIDTH_BIT-1:0] a,
  input  logic [WIDTH_BIT-1:0] b,
  output logic [ACC_WIDTH-1:0] sum,
  output logic [ACC_WIDTH-1:0] acc
);

  logic [ACC_WIDTH-1:0] prod;
  logic [ACC_WIDTH-1:0] acc_d;
  logic [ACC_WIDTH-1:0] acc_q;

  // Operands are widened first so the product is computed at full precision.
  assign prod = ACC_WIDTH'(a) * ACC_WIDTH'(b);
  assign sum  = first ? prod : acc_q + prod;
  assign acc  = acc_q;

  always_comb begin
    acc_d = acc_q;
    if (clear) begin
      acc_d = '0;
    end else if (en) begin
      acc_d = sum;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      acc_q <= '0;
    end else begin
      acc_q <= acc_d;
    end
  end

endmodule

// File: rtl/matrix_mac_accumulator.sv
// Consumes the row-major (Aik, Bkj) stream, accumulates over k and writes C[i][j].
module matrix_mac_accumulator
  import matrix_pkg::*;
#(
  parameter int AROWS     = 2,
  parameter int ACOLUMNS  = 2,
  parameter int BCOLUMNS  = 2,
  parameter int WIDTH_BIT = 8
) (
  input  logic                     clock,
  input  logic                     reset,
  matrix_mac_accumulator_if.slave  bus
);

  localparam int ACC_WIDTH = acc_width(WIDTH_BIT, ACOLUMNS);
  localparam int ROW_W     = $clog2(AROWS) + 1;
  localparam int COL_W     = $clog2(BCOLUMNS) + 1;
  localparam int K_W       = $clog2(ACOLUMNS) + 1;

  typedef logic [AROWS-1:0][BCOLUMNS-1:0][ACC_WIDTH-1:0] matrix_t;

  mac_state_t           state_d, state_q;
  logic [K_W-1:0]       k_d, k_q;
  logic [COL_W-1:0]     j_d, j_q;
  logic [ROW_W-1:0]     i_d, i_q;
  logic                 c_valid_d, c_valid_q;
  logic [ROW_W-1:0]     c_row_d, c_row_q;
  logic [COL_W-1:0]     c_col_d, c_col_q;
  logic [ACC_WIDTH-1:0] c_value_d, c_value_q;
  matrix_t              matrix_d, matrix_q;

  logic                 cell_clear;
  logic                 cell_en;
  logic                 last_k, last_j, last_i;
  logic [ACC_WIDTH-1:0] sum;
  logic [ACC_WIDTH-1:0] acc;

  assign last_k = (k_q == K_W'(ACOLUMNS - 1));
  assign last_j = (j_q == COL_W'(BCOLUMNS - 1));
  assign last_i = (i_q == ROW_W'(AROWS - 1));

  matrix_mac_cell #(
    .WIDTH_BIT (WIDTH_BIT),
    .ACC_WIDTH (ACC_WIDTH)
  ) u_cell (
    .clock (clock),
    .reset (reset),
    .clear (cell_clear),
    .en    (cell_en),
    .first (k_q == '0),
    .a     (bus.Aik),
    .b     (bus.Bkj),
    .sum   (sum),
    .acc   (acc)
  );

  always_comb begin
    state_d    = state_q;
    k_d        = k_q;
    j_d        = j_q;
    i_d        = i_q;
    c_valid_d  = 1'b0;
    c_row_d    = c_row_q;
    c_col_d    = c_col_q;
    c_value_d  = c_value_q;
    matrix_d   = matrix_q;
    cell_clear = 1'b0;
    cell_en    = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (bus.start) begin
          state_d    = RUN;
          k_d        = '0;
          j_d        = '0;
          i_d        = '0;
          cell_clear = 1'b1;
        end
      end

      RUN: begin
        if (bus.in_valid) begin
          if (last_k) begin
            // Final k beat: the combinational sum is the finished element.
            for (int r = 0; r < AROWS; r++) begin
              for (int c = 0; c < BCOLUMNS; c++) begin
                if (i_q == ROW_W'(r) && j_q == COL_W'(c)) begin
                  matrix_d[r][c] = sum;
                end
              end
            end
            c_valid_d = 1'b1;
            c_row_d   = i_q;
            c_col_d   = j_q;
            c_value_d = sum;
            k_d       = '0;
            if (last_j) begin
              j_d = '0;
              if (last_i) begin
                i_d     = '0;
                state_d = DONE;
              end else begin
                i_d = i_q + ROW_W'(1);
              end
            end else begin
              j_d = j_q + COL_W'(1);
            end
          end else begin
            cell_en = 1'b1;
            k_d     = k_q + K_W'(1);
          end
        end
      end

      DONE: begin
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q   <= IDLE;
      k_q       <= '0;
      j_q       <= '0;
      i_q       <= '0;
      c_valid_q <= 1'b0;
      c_row_q   <= '0;
      c_col_q   <= '0;
      c_value_q <= '0;
      matrix_q  <= '0;
    end else begin
      state_q   <= state_d;
      k_q       <= k_d;
      j_q       <= j_d;
      i_q       <= i_d;
      c_valid_q <= c_valid_d;
      c_row_q   <= c_row_d;
      c_col_q   <= c_col_d;
      c_value_q <= c_value_d;
      matrix_q  <= matrix_d;
    end
  end

  assign bus.busy    = (state_q != IDLE);
  assign bus.done    = (state_q == DONE);
  assign bus.c_valid = c_valid_q;
  assign bus.c_row   = c_row_q;
  assign bus.c_col   = c_col_q;
  assign bus.c_value = c_value_q;
  assign bus.MatrixC = matrix_q;
  assign bus.state   = state_q;
  assign bus.acc_dbg = acc;

endmodule

// File: tb/tb_matrix_mac_accumulator.sv
// Directed bench: 2x2x2 instance driven from a vector table, plus a 3x1x3 instance.
module tb_matrix_mac_accumulator;
  import matrix_pkg::*;

  localparam int ACC0 = acc_width(8, 2);
  localparam int ACC1 = acc_width(8, 1);

  logic clock = 1'b0;
  logic reset;
  always #5 clock = ~clock;

  matrix_mac_accumulator_if #(.AROWS(2), .ACOLUMNS(2), .BCOLUMNS(2), .WIDTH_BIT(8)) bus0 ();
  matrix_mac_accumulator_if #(.AROWS(3), .ACOLUMNS(1), .BCOLUMNS(3), .WIDTH_BIT(8)) bus1 ();

  matrix_mac_accumulator #(.AROWS(2), .ACOLUMNS(2), .BCOLUMNS(2), .WIDTH_BIT(8)) dut0 (
    .clock (clock),
    .reset (reset),
    .bus   (bus0)
  );

  matrix_mac_accumulator #(.AROWS(3), .ACOLUMNS(1), .BCOLUMNS(3), .WIDTH_BIT(8)) dut1 (
    .clock (clock),
    .reset (reset),
    .bus   (bus1)
  );

  int errors = 0;
  int checks = 0;

  // Expected result pulses of dut0, packed as {row, col, value}.
  logic [ACC0+3:0] exp_q[$];
  logic [ACC0+3:0] mon_e;

  typedef struct {
    logic [7:0]  a;
    logic [7:0]  b;
    logic        exp_v;
    logic [1:0]  row;
    logic [1:0]  col;
    logic [31:0] val;
  } vec_t;

  vec_t tbl[8];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  always @(negedge clock) begin
    if (bus0.c_valid === 1'b1) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL spurious_c_valid: got row=%0d col=%0d value=%0d expected no pulse",
                 bus0.c_row, bus0.c_col, bus0.c_value);
      end else begin
        mon_e = exp_q.pop_front();
        check("c_result_packed", 32'({bus0.c_row, bus0.c_col, bus0.c_value}), 32'(mon_e));
      end
    end
  end

  task automatic drive0(input logic s, input logic v, input logic [7:0] a, input logic [7:0] b);
    bus0.start    = s;
    bus0.in_valid = v;
    bus0.Aik      = a;
    bus0.Bkj      = b;
    @(posedge clock);
    #1;
  endtask

  task automatic start0();
    drive0(1'b1, 1'b1, 8'd100, 8'd100);
    check("start_busy", 32'(bus0.busy), 32'd1);
    check("start_c_valid", 32'(bus0.c_valid), 32'd0);
  endtask

  task automatic run_tbl(input bit gaps);
    for (int n = 0; n < 8; n++) begin
      if (tbl[n].exp_v) exp_q.push_back({tbl[n].row, tbl[n].col, ACC0'(tbl[n].val)});
      drive0(1'b0, 1'b1, tbl[n].a, tbl[n].b);
      check("beat_c_valid", 32'(bus0.c_valid), 32'(tbl[n].exp_v));
      check("beat_done", 32'(bus0.done), 32'(n == 7));
      check("beat_busy", 32'(bus0.busy), 32'd1);
      if (gaps && n != 7) begin
        drive0(1'b1, 1'b0, 8'hAA, 8'h55);
        check("gap_c_valid", 32'(bus0.c_valid), 32'd0);
        check("gap_busy", 32'(bus0.busy), 32'd1);
      end
    end
    drive0(1'b0, 1'b0, 8'd0, 8'd0);
    check("post_busy", 32'(bus0.busy), 32'd0);
    check("post_done", 32'(bus0.done), 32'd0);
    check("post_c_valid", 32'(bus0.c_valid), 32'd0);
  endtask

  task automatic check_c0(input int c00, input int c01, input int c10, input int c11);
    check("MatrixC00", 32'(bus0.MatrixC[0][0]), c00);
    check("MatrixC01", 32'(bus0.MatrixC[0][1]), c01);
    check("MatrixC10", 32'(bus0.MatrixC[1][0]), c10);
    check("MatrixC11", 32'(bus0.MatrixC[1][1]), c11);
  endtask

  task automatic check_zero0();
    check("rst_busy", 32'(bus0.busy), 32'd0);
    check("rst_c_valid", 32'(bus0.c_valid), 32'd0);
    check("rst_done", 32'(bus0.done), 32'd0);
    check("rst_c_row", 32'(bus0.c_row), 32'd0);
    check("rst_c_col", 32'(bus0.c_col), 32'd0);
    check("rst_c_value", 32'(bus0.c_value), 32'd0);
    check_c0(0, 0, 0, 0);
  endtask

  initial begin
    // A=[[1,2],[3,4]], B=[[5,6],[7,8]] streamed i, j, k order.
    tbl[0] = '{8'd1, 8'd5, 1'b0, 2'd0, 2'd0, 32'd0};
    tbl[1] = '{8'd2, 8'd7, 1'b1, 2'd0, 2'd0, 32'd19};
    tbl[2] = '{8'd1, 8'd6, 1'b0, 2'd0, 2'd0, 32'd0};
    tbl[3] = '{8'd2, 8'd8, 1'b1, 2'd0, 2'd1, 32'd22};
    tbl[4] = '{8'd3, 8'd5, 1'b0, 2'd0, 2'd0, 32'd0};
    tbl[5] = '{8'd4, 8'd7, 1'b1, 2'd1, 2'd0, 32'd43};
    tbl[6] = '{8'd3, 8'd6, 1'b0, 2'd0, 2'd0, 32'd0};
    tbl[7] = '{8'd4, 8'd8, 1'b1, 2'd1, 2'd1, 32'd50};

    reset         = 1'b1;
    bus0.start    = 1'b0;
    bus0.in_valid = 1'b0;
    bus0.Aik      = '0;
    bus0.Bkj      = '0;
    bus1.start    = 1'b0;
    bus1.in_valid = 1'b0;
    bus1.Aik      = '0;
    bus1.Bkj      = '0;
    repeat (2) @(posedge clock);
    #1;
    check_zero0();
    check("rst1_c_valid", 32'(bus1.c_valid), 32'd0);
    check("rst1_busy", 32'(bus1.busy), 32'd0);
    reset = 1'b0;

    // Operands while idle are not consumed.
    drive0(1'b0, 1'b1, 8'd9, 8'd9);
    drive0(1'b0, 1'b1, 8'd9, 8'd9);
    check("idle_busy", 32'(bus0.busy), 32'd0);
    check("idle_c_valid", 32'(bus0.c_valid), 32'd0);
    check_c0(0, 0, 0, 0);

    start0();
    run_tbl(1'b0);
    check_c0(19, 22, 43, 50);

    // Same stream with gaps carrying stray start; start must not clear MatrixC.
    start0();
    check("start_keeps_c00", 32'(bus0.MatrixC[0][0]), 32'd19);
    run_tbl(1'b1);
    check_c0(19, 22, 43, 50);

    // Full-scale operands.
    start0();
    for (int n = 0; n < 8; n++) begin
      if (n % 2 == 1) exp_q.push_back({2'(n / 4), 2'((n / 2) % 2), ACC0'(130050)});
      drive0(1'b0, 1'b1, 8'd255, 8'd255);
      check("max_c_valid", 32'(bus0.c_valid), 32'(n % 2 == 1));
      if (n % 2 == 1) check("max_c_value", 32'(bus0.c_value), 32'd130050);
    end
    drive0(1'b0, 1'b0, 8'd0, 8'd0);
    check_c0(130050, 130050, 130050, 130050);

    // Reset after five beats, then a clean run.
    start0();
    for (int n = 0; n < 5; n++) begin
      if (tbl[n].exp_v) exp_q.push_back({tbl[n].row, tbl[n].col, ACC0'(tbl[n].val)});
      drive0(1'b0, 1'b1, tbl[n].a, tbl[n].b);
    end
    reset = 1'b1;
    drive0(1'b0, 1'b1, tbl[5].a, tbl[5].b);
    check_zero0();
    reset = 1'b0;
    start0();
    run_tbl(1'b0);
    check_c0(19, 22, 43, 50);

    // Single-depth 3x3 instance: every beat completes an element.
    bus1.start = 1'b1;
    @(posedge clock);
    #1;
    bus1.start = 1'b0;
    check("d1_start_busy", 32'(bus1.busy), 32'd1);
    for (int n = 0; n < 9; n++) begin
      bus1.in_valid = 1'b1;
      bus1.Aik      = 8'(n + 1);
      bus1.Bkj      = 8'd2;
      @(posedge clock);
      #1;
      check("d1_c_valid", 32'(bus1.c_valid), 32'd1);
      check("d1_c_value", 32'(bus1.c_value), 32'(2 * (n + 1)));
      check("d1_c_row", 32'(bus1.c_row), 32'(n / 3));
      check("d1_c_col", 32'(bus1.c_col), 32'(n % 3));
      check("d1_done", 32'(bus1.done), 32'(n == 8));
    end
    bus1.in_valid = 1'b0;
    @(posedge clock);
    #1;
    check("d1_post_busy", 32'(bus1.busy), 32'd0);
    check("d1_post_c_valid", 32'(bus1.c_valid), 32'd0);
    for (int r = 0; r < 3; r++) begin
      for (int c = 0; c < 3; c++) begin
        check("d1_MatrixC", 32'(bus1.MatrixC[r][c]), 32'(2 * (3 * r + c + 1)));
      end
    end
    check("d1_acc_width", 32'(ACC1), 32'($bits(bus1.c_value)));

    @(negedge clock);
    check("pending_results", 32'(exp_q.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
